// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed little-endian storage with byte/half/word
// stores, fixed-latency pipelined loads with RISC-V extension, and fault counting.
module dmem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic [31:0] read_addr,
  input  logic [2:0]  read_width,
  input  logic        write_enable,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  input  logic [2:0]  write_width,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        read_fault,
  output logic        write_fault,
  output logic [7:0]  fault_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LAST  = READ_LATENCY - 1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Interface: read_enable/write_enable are single-cycle qualifiers with no
  // backpressure; every accepted read yields exactly one read_valid pulse
  // READ_LATENCY cycles later, in request order.

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [1:0]            rd_lane;
  logic                  rd_fault_req;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [1:0]            wr_lane;
  logic                  wr_fault_req;
  logic [3:0]            wr_be;
  logic [31:0]           wr_word;
  logic                  wr_do;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{read_addr[31:ADDR_WIDTH+2], write_addr[31:ADDR_WIDTH+2]};

  assign rd_idx  = read_addr[ADDR_WIDTH+1:2];
  assign rd_lane = read_addr[1:0];
  assign wr_idx  = write_addr[ADDR_WIDTH+1:2];
  assign wr_lane = write_addr[1:0];

  always_comb begin
    rd_fault_req = 1'b0;
    case (read_width)
      F3_B, F3_BU: rd_fault_req = 1'b0;
      F3_H, F3_HU: rd_fault_req = read_addr[0];
      F3_W:        rd_fault_req = |read_addr[1:0];
      default:     rd_fault_req = 1'b1;
    endcase
  end

  always_comb begin
    wr_fault_req = 1'b0;
    wr_be        = 4'b0000;
    wr_word      = write_data;
    case (write_width)
      F3_B: begin
        wr_be   = 4'b0001 << wr_lane;
        wr_word = {4{write_data[7:0]}};
      end
      F3_H: begin
        wr_fault_req = wr_lane[0];
        wr_be        = wr_lane[1] ? 4'b1100 : 4'b0011;
        wr_word      = {2{write_data[15:0]}};
      end
      F3_W: begin
        wr_fault_req = |wr_lane;
        wr_be        = 4'b1111;
        wr_word      = write_data;
      end
      default: wr_fault_req = 1'b1;
    endcase
  end

  // Stores are suppressed while reset is high so a reset glitch cannot corrupt memory.
  assign wr_do = write_enable & ~wr_fault_req & ~reset;

  always_ff @(posedge clk) begin
    if (wr_do) begin
      if (wr_be[0]) mem_q[wr_idx][7:0]   <= wr_word[7:0];
      if (wr_be[1]) mem_q[wr_idx][15:8]  <= wr_word[15:8];
      if (wr_be[2]) mem_q[wr_idx][23:16] <= wr_word[23:16];
      if (wr_be[3]) mem_q[wr_idx][31:24] <= wr_word[31:24];
    end
  end

  // Read pipeline: stage 0 holds the registered storage read plus request metadata.
  logic [READ_LATENCY-1:0]       p_valid_q, p_valid_d;
  logic [READ_LATENCY-1:0]       p_fault_q, p_fault_d;
  logic [READ_LATENCY-1:0][1:0]  p_lane_q,  p_lane_d;
  logic [READ_LATENCY-1:0][2:0]  p_width_q, p_width_d;
  logic [READ_LATENCY-1:0][31:0] p_word_q,  p_word_d;

  always_comb begin
    p_valid_d = p_valid_q;
    p_fault_d = p_fault_q;
    p_lane_d  = p_lane_q;
    p_width_d = p_width_q;
    p_word_d  = p_word_q;

    p_valid_d[0] = read_enable;
    if (read_enable) begin
      p_fault_d[0] = rd_fault_req;
      p_lane_d[0]  = rd_lane;
      p_width_d[0] = read_width;
      p_word_d[0]  = mem_q[rd_idx];
    end

    // Payload only advances with a valid entry so the output holds between loads.
    for (int i = 1; i < READ_LATENCY; i++) begin
      p_valid_d[i] = p_valid_q[i-1];
      if (p_valid_q[i-1]) begin
        p_fault_d[i] = p_fault_q[i-1];
        p_lane_d[i]  = p_lane_q[i-1];
        p_width_d[i] = p_width_q[i-1];
        p_word_d[i]  = p_word_q[i-1];
      end
    end
  end

  logic [7:0] fault_count_q, fault_count_d;
  logic       write_fault_q, write_fault_d;
  logic [8:0] fc_sum;

  always_comb begin
    fc_sum = {1'b0, fault_count_q}
           + {8'd0, read_enable & rd_fault_req}
           + {8'd0, write_enable & wr_fault_req};
    fault_count_d = fc_sum[8] ? 8'hFF : fc_sum[7:0];
    write_fault_d = write_enable & wr_fault_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid_q     <= '0;
      p_fault_q     <= '0;
      p_lane_q      <= '0;
      p_width_q     <= '0;
      p_word_q      <= '0;
      fault_count_q <= 8'd0;
      write_fault_q <= 1'b0;
    end else begin
      p_valid_q     <= p_valid_d;
      p_fault_q     <= p_fault_d;
      p_lane_q      <= p_lane_d;
      p_width_q     <= p_width_d;
      p_word_q      <= p_word_d;
      fault_count_q <= fault_count_d;
      write_fault_q <= write_fault_d;
    end
  end

  logic [31:0] out_word;
  logic [1:0]  out_lane;
  logic [7:0]  out_byte;
  logic [15:0] out_half;
  logic [31:0] out_data;

  always_comb begin
    out_word = p_word_q[LAST];
    out_lane = p_lane_q[LAST];
    out_byte = 8'(out_word >> {out_lane, 3'b000});
    out_half = out_lane[1] ? out_word[31:16] : out_word[15:0];
    out_data = 32'd0;
    if (!p_fault_q[LAST]) begin
      case (p_width_q[LAST])
        F3_B:    out_data = {{24{out_byte[7]}}, out_byte};
        F3_BU:   out_data = {24'd0, out_byte};
        F3_H:    out_data = {{16{out_half[15]}}, out_half};
        F3_HU:   out_data = {16'd0, out_half};
        F3_W:    out_data = out_word;
        default: out_data = 32'd0;
      endcase
    end
  end

  assign read_data   = out_data;
  assign read_valid  = p_valid_q[LAST];
  assign read_fault  = p_valid_q[LAST] & p_fault_q[LAST];
  assign write_fault = write_fault_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random loads/stores checked against a
// byte-array memory model with a due-cycle response queue.
module tb_dmem_responder;

  localparam int AW     = 10;
  localparam int RL     = 3;
  localparam int NBYTES = 4 * (2 ** AW);

  logic        clk;
  logic        reset;
  logic        read_enable;
  logic [31:0] read_addr;
  logic [2:0]  read_width;
  logic        write_enable;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [2:0]  write_width;
  logic [31:0] read_data;
  logic        read_valid;
  logic        read_fault;
  logic        write_fault;
  logic [7:0]  fault_count;

  dmem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk          (clk),
    .reset        (reset),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_width   (read_width),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_width  (write_width),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .read_fault   (read_fault),
    .write_fault  (write_fault),
    .fault_count  (fault_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic [7:0]  ref_bytes [NBYTES];
  logic [32:0] exp_q [$];
  int          due_q [$];
  int          vectors;
  int          miscompares;
  int          cycle;
  int          fc_model;
  logic [31:0] last_data;
  logic        wf_exp;

  function automatic int size_of(input logic [2:0] w);
    if (w[1:0] == 2'd0) return 1;
    if (w[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit rd_faults(input logic [31:0] a, input logic [2:0] w);
    case (w)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic bit wr_faults(input logic [31:0] a, input logic [2:0] w);
    case (w)
      3'd0:    return 1'b0;
      3'd1:    return (a % 2) != 0;
      3'd2:    return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] w);
    int          n;
    int          base;
    logic [31:0] v;
    n    = size_of(w);
    base = int'(a % NBYTES);
    v    = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[(base + k) % NBYTES]) << (8 * k));
    if (!w[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
    int n;
    int base;
    n    = size_of(w);
    base = int'(a % NBYTES);
    for (int k = 0; k < n; k++) ref_bytes[(base + k) % NBYTES] = 8'(d >> (8 * k));
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [32:0] e;
    if (due_q.size() > 0 && due_q[0] == cycle) begin
      void'(due_q.pop_front());
      e = exp_q.pop_front();
      check("read_valid", 32'(read_valid), 32'd1);
      check("read_fault", 32'(read_fault), 32'(e[32]));
      check("read_data", read_data, e[31:0]);
      last_data = e[31:0];
    end else begin
      check("read_valid_idle", 32'(read_valid), 32'd0);
      check("read_fault_idle", 32'(read_fault), 32'd0);
      check("read_data_hold", read_data, last_data);
    end
    check("write_fault", 32'(write_fault), 32'(wf_exp));
    check("fault_count", 32'(fault_count), 32'(fc_model));
  endtask

  // driver: one clock edge with the given request fields
  task automatic step(input bit re, input logic [31:0] ra, input logic [2:0] rw,
                      input bit we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [2:0] ww);
    int faults;
    read_enable  = re;
    read_addr    = ra;
    read_width   = rw;
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    write_width  = ww;
    faults = 0;
    if (re) begin
      due_q.push_back(cycle + RL);
      if (rd_faults(ra, rw)) begin
        exp_q.push_back({1'b1, 32'd0});
        faults++;
      end else begin
        exp_q.push_back({1'b0, ref_load(ra, rw)});
      end
    end
    wf_exp = 1'b0;
    if (we) begin
      if (wr_faults(wa, ww)) begin
        wf_exp = 1'b1;
        faults++;
      end else begin
        ref_store(wa, ww, wd);
      end
    end
    fc_model = (fc_model + faults > 255) ? 255 : fc_model + faults;
    @(posedge clk);
    cycle++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] w);
    step(1'b1, a, w, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    step(1'b0, 32'd0, 3'd0, 1'b1, a, d, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  // Async reset with a store held on the bus; memory must ignore it.
  task automatic do_reset();
    read_enable  = 1'b0;
    write_enable = 1'b1;
    write_addr   = 32'h10;
    write_data   = 32'h0;
    write_width  = 3'd2;
    #1 reset = 1'b1;
    #1;
    exp_q.delete();
    due_q.delete();
    fc_model  = 0;
    last_data = 32'd0;
    wf_exp    = 1'b0;
    check("rst_read_valid", 32'(read_valid), 32'd0);
    check("rst_read_fault", 32'(read_fault), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_write_fault", 32'(write_fault), 32'd0);
    check("rst_fault_count", 32'(fault_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset        = 1'b0;
    write_enable = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    fc_model    = 0;
    last_data   = 32'd0;
    wf_exp      = 1'b0;
    reset        = 1'b1;
    read_enable  = 1'b0;
    read_addr    = 32'd0;
    read_width   = 3'd0;
    write_enable = 1'b0;
    write_addr   = 32'd0;
    write_data   = 32'd0;
    write_width  = 3'd0;
    #12;
    check("init_read_valid", 32'(read_valid), 32'd0);
    check("init_read_data", read_data, 32'd0);
    check("init_fault_count", 32'(fault_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Give every word a defined value.
    for (int i = 0; i < 2 ** AW; i++) wr(32'(4 * i), $urandom(), 3'd2);

    // Store and reload with every load width.
    wr(32'h10, 32'hDEADBEEF, 3'd2);
    rd(32'h10, 3'd2);
    rd(32'h13, 3'd0);
    rd(32'h13, 3'd4);
    rd(32'h12, 3'd1);
    rd(32'h10, 3'd5);
    idle(RL);

    // Byte/half merge into a cleared word.
    wr(32'h20, 32'h0, 3'd2);
    wr(32'h21, 32'h5A, 3'd0);
    wr(32'h22, 32'h1234, 3'd1);
    rd(32'h20, 3'd2);
    idle(RL);

    // Misalignment and illegal widths.
    rd(32'h11, 3'd2);
    wr(32'h23, 32'hFFFF, 3'd1);
    rd(32'h20, 3'd2);
    rd(32'h0, 3'd3);
    wr(32'h24, 32'h1, 3'd7);
    step(1'b1, 32'h2, 3'd6, 1'b1, 32'h2, 32'h0, 3'd2);
    idle(RL);

    // Same-cycle read/write to one word returns old data.
    wr(32'h40, 32'h11111111, 3'd2);
    step(1'b1, 32'h40, 3'd2, 1'b1, 32'h40, 32'h22222222, 3'd2);
    rd(32'h40, 3'd2);
    idle(RL);

    // Back-to-back loads and address wrap.
    rd(32'h0, 3'd2);
    rd(32'h4, 3'd2);
    rd(32'h8, 3'd2);
    rd(32'hC, 3'd2);
    rd(32'(NBYTES), 3'd2);
    rd(32'hFFFF_FFFF, 3'd4);
    idle(RL);

    // Reset while a load is in flight.
    rd(32'h10, 3'd2);
    idle(1);
    do_reset();
    idle(RL + 2);
    rd(32'h10, 3'd2);
    idle(RL);

    // Random mix, biased to a small window for hazards.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra;
      logic [31:0] wa;
      ra = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 63));
      wa = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 63));
      step(1'($urandom_range(0, 1)), ra, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), wa, $urandom(), 3'($urandom_range(0, 3)));
    end
    idle(RL);

    // Fault burst to saturate the counter, some cycles with double faults.
    for (int i = 0; i < 260; i++) begin
      if (i % 10 == 0) step(1'b1, 32'h1, 3'd2, 1'b1, 32'h3, 32'h0, 3'd1);
      else             rd(32'h1, 3'd2);
    end
    idle(RL);
    check("fault_count_saturated", 32'(fault_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
